modexp_result_unloader: RTL and testbench

Downstream stage of the 512-bit modular-exponentiation core: detects the core's `done` rising edge and captures the 512-bit result. Streams the result out over the 128-bit bus as four beats with valid/ready backpressure, least-significant slice first, matching the operand load order. Flags a zero result as a fault hint and flags results lost because the previous one was still draining.

---
 rtl/modexp_pkg.sv | 16 +
 rtl/modexp_result_unloader_piso_shift.sv | 36 +++
 rtl/modexp_result_unloader.sv | 96 +++++++++
 tb/tb_modexp_result_unloader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared constants for the 512-bit modular-exponentiation datapath.
// The core, the operand loader and the result unloader all size their
// buses from these values, so the bus width is defined in one place.
// Also holds the unloader's state encoding.
package modexp_pkg;

    localparam int MODEXP_DATA_W = 512;
    localparam int MODEXP_BUS_W  = 128;
    localparam int MODEXP_BEATS  = MODEXP_DATA_W / MODEXP_BUS_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unload_state_t;

endpackage

// File: rtl/modexp_result_unloader_piso_shift.sv
// piso_shift: parallel-in / serial-out shift register.
// Loads a DATA_W word and presents its low BUS_W bits; each shift moves the
// word right by BUS_W, filling with zeros. Load has priority over shift.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears the register)
//   load       capture din
//   shift      advance by one BUS_W slice
//   din        DATA_W parallel input
//   dout       BUS_W current slice (low bits of the register)
module piso_shift #(
    parameter int DATA_W = 512,
    parameter int BUS_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [BUS_W-1:0]  dout
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg >> BUS_W;
        end
    end

    assign dout = sreg[BUS_W-1:0];

endmodule

// File: rtl/modexp_result_unloader.sv
// modexp_result_unloader: captures the exponentiation core's result on the
// rising edge of its done level and streams it out least-significant slice
// first as BEATS beats with valid/ready flow control.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   res_done    core done level (stays high after completion)
//   res_data    core result, valid while res_done is high
//   out_data    current beat
//   out_valid   beat available
//   out_ready   consumer accepts the beat
//   out_last    current beat is the final one
//   busy        a captured result is still draining
//   res_zero    last captured result was zero (fault hint)
//   overrun     sticky: a result arrived while busy and was dropped
module modexp_result_unloader
    import modexp_pkg::*;
#(
    parameter int DATA_W = MODEXP_DATA_W,
    parameter int BUS_W  = MODEXP_BUS_W,
    parameter int BEATS  = DATA_W / BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_done,
    input  logic [DATA_W-1:0] res_data,
    output logic [BUS_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              res_zero,
    output logic              overrun
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    unload_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             done_q;

    logic capture;
    logic hs;
    logic final_hs;
    logic load;
    logic shift;

    assign capture  = res_done & ~done_q;
    assign hs       = out_valid & out_ready;
    assign final_hs = hs & (cnt == LAST_BEAT);
    // A new result is accepted only when nothing is in flight or the
    // in-flight stream finishes this very cycle (back-to-back).
    assign load     = capture & ((state == IDLE) | final_hs);
    assign shift    = hs & ~load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            res_zero <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done_q <= res_done;
            if (load) begin
                cnt      <= '0;
                res_zero <= (res_data == '0);
                state    <= SEND;
            end else if (final_hs) begin
                state <= IDLE;
            end else if (hs) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture & ~load) begin
                overrun <= 1'b1;
            end
        end
    end

    piso_shift #(
        .DATA_W (DATA_W),
        .BUS_W  (BUS_W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (res_data),
        .dout  (out_data)
    );

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) & (cnt == LAST_BEAT);

endmodule

// File: tb/tb_modexp_result_unloader.sv
// Bench for modexp_result_unloader: directed scenarios followed by random
// traffic, checked each cycle against a queue-based model of the stream.
module tb_modexp_result_unloader;

    localparam int DW = 512;
    localparam int BW = 128;
    localparam int NB = DW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_done;
    logic [DW-1:0] res_data;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          res_zero;
    logic          overrun;

    int n_vec  = 0;
    int n_miss = 0;

    // model state
    logic [BW-1:0] m_q[$];
    logic          m_prev;
    logic          m_zero;
    logic          m_ovr;

    modexp_result_unloader dut (
        .clk       (clk),
        .rst       (rst),
        .res_done  (res_done),
        .res_data  (res_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .res_zero  (res_zero),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs with the model, apply the next inputs, advance the
    // model across the coming clock edge, then wait for the next falling edge.
    task automatic cycle(input logic d, input logic [DW-1:0] dat, input logic rdy, input logic r);
        logic vld;
        logic edge_ev;
        vld = (m_q.size() != 0);
        chk("out_valid", BW'(out_valid), BW'(vld));
        chk("busy", BW'(busy), BW'(vld));
        chk("out_last", BW'(out_last), BW'(m_q.size() == 1));
        if (vld) chk("out_data", out_data, m_q[0]);
        chk("res_zero", BW'(res_zero), BW'(m_zero));
        chk("overrun", BW'(overrun), BW'(m_ovr));

        res_done  = d;
        res_data  = dat;
        out_ready = rdy;
        rst       = r;

        if (r) begin
            m_q.delete();
            m_prev = 1'b0;
            m_zero = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            edge_ev = d & ~m_prev;
            if (vld && rdy) void'(m_q.pop_front());
            if (edge_ev) begin
                if (m_q.size() == 0) begin
                    for (int i = 0; i < NB; i++) m_q.push_back(dat[i*BW +: BW]);
                    m_zero = (dat == '0);
                end else begin
                    m_ovr = 1'b1;
                end
            end
            m_prev = d;
        end
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [DW-1:0] abcd;
    logic [6:0]    bp_pat;

    initial begin
        abcd = {128'hD, 128'hC, 128'hB, 128'hA};
        bp_pat = 7'b1011001; // bit 0 first: 1,0,0,1,1,0,1
        m_q.delete();
        m_prev = 1'b0;
        m_zero = 1'b0;
        m_ovr  = 1'b0;
        rst = 1'b1; res_done = 1'b0; res_data = '0; out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("reset_out_data", out_data, '0);

        // basic stream
        for (int i = 0; i < 7; i++) cycle(1'b1, abcd, 1'b1, 1'b0);
        cycle(1'b0, abcd, 1'b1, 1'b0);

        // backpressure
        cycle(1'b1, abcd, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, abcd, bp_pat[i], 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, abcd, 1'b1, 1'b0);

        // level hold
        for (int i = 0; i < 21; i++) cycle(1'b1, rand_data(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // overrun: second rise during beat 1
        cycle(1'b1, abcd, 1'b1, 1'b0);
        cycle(1'b0, abcd, 1'b1, 1'b0);
        cycle(1'b1, rand_data(), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, abcd, 1'b1, 1'b0);
        chk("overrun_sticky", BW'(overrun), BW'(1'b1));
        cycle(1'b0, '0, 1'b1, 1'b1); // clear sticky flag
        cycle(1'b0, '0, 1'b1, 1'b0);

        // back-to-back: second rise with beat 3
        cycle(1'b1, abcd, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, abcd, 1'b1, 1'b0);
        cycle(1'b1, rand_data(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // zero result, reset during beat 2
        cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b1, '0, 1'b1, 1'b1);
        chk("rst_out_data", out_data, '0);
        for (int i = 0; i < 4; i++) cycle(1'b1, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic          d;
            logic [DW-1:0] dat;
            d   = ($urandom_range(0, 3) != 0) ? res_done : ~res_done;
            dat = ($urandom_range(0, 9) == 0) ? '0 : rand_data();
            cycle(d, dat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
